ir_regfile_cc: RTL

Instruction register, eight-entry general-purpose register file, NZP condition codes and branch-enable flag for the LC-3 datapath, sitting directly upstream of the instruction sequencer/decoder. It captures the fetched instruction and write-back values from the shared 16-bit bus under the sequencer's load strobes. It returns `Opcode`, `IR_5`, `IR_11` and `BEN` to the sequencer, and drives the SR1/SR2 operands to the ALU and address adders.

---
 rtl/ir_regfile_cc.sv | 89 ++++++++
 1 files changed

// File: rtl/ir_regfile_cc.sv
// LC-3 instruction register, eight-entry register file, NZP condition codes and branch enable.
// All loads sample the shared Bus on the rising edge of Clk and use pre-edge IR/NZP.
module ir_regfile_cc #(
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus,
  input  logic        LD_IR,
  input  logic        LD_REG,
  input  logic        LD_CC,
  input  logic        LD_BEN,
  input  logic        DRMUX,
  input  logic        SR1MUX,
  output logic [15:0] IR,
  output logic [3:0]  Opcode,
  output logic        IR_5,
  output logic        IR_11,
  output logic        BEN,
  output logic [2:0]  NZP,
  output logic [15:0] SR1_OUT,
  output logic [15:0] SR2_OUT
);

  logic [15:0] r_ir;
  logic [15:0] r_regs [8];
  logic [2:0]  r_nzp;
  logic        r_ben;

  logic [2:0]  w_dr;
  logic [2:0]  w_sr1;
  logic [2:0]  w_cc_next;
  logic [7:0]  w_we;

  assign w_dr  = DRMUX  ? 3'b111      : r_ir[11:9];
  assign w_sr1 = SR1MUX ? r_ir[8:6]   : r_ir[11:9];

  always_comb begin
    w_cc_next = 3'b001;
    if (Bus[15])
      w_cc_next = 3'b100;
    else if (Bus == 16'h0000)
      w_cc_next = 3'b010;
  end

  // One write enable per register; DR is decoded from the IR held before this edge.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_we
      assign w_we[gi] = LD_REG && (w_dr == 3'(gi));
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++)
        r_regs[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++)
        if (w_we[i])
          r_regs[i] <= Bus;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ir  <= 16'h0000;
      r_nzp <= CC_RESET;
      r_ben <= 1'b0;
    end else begin
      if (LD_IR)
        r_ir <= Bus;
      if (LD_CC)
        r_nzp <= w_cc_next;
      if (LD_BEN)
        r_ben <= |(r_ir[11:9] & r_nzp);
    end
  end

  assign IR      = r_ir;
  assign Opcode  = r_ir[15:12];
  assign IR_5    = r_ir[5];
  assign IR_11   = r_ir[11];
  assign BEN     = r_ben;
  assign NZP     = r_nzp;
  assign SR1_OUT = r_regs[w_sr1];
  assign SR2_OUT = r_regs[r_ir[2:0]];

endmodule
